// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the single-port RAM sequencer/arbiter.
package ram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MAX_NREQ = 8;

    function automatic int onehot_to_idx(input logic [MAX_NREQ-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_sp_arb_if.sv
// Requester-side and RAM-side bus of the shared single-port RAM arbiter.
interface ram_sp_arb_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9,
    parameter int NREQ      = 2
);
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0]           req_we;
    logic [NREQ*ADDRWIDTH-1:0] req_addr;
    logic [NREQ*DATAWIDTH-1:0] req_wr_data;
    logic [NREQ-1:0]           ack;
    logic [NREQ-1:0]           rd_valid;
    logic [DATAWIDTH-1:0]      rd_data;
    logic [ADDRWIDTH-1:0]      ram_addr;
    logic                      ram_we;
    logic [DATAWIDTH-1:0]      ram_wr_data;
    logic [DATAWIDTH-1:0]      ram_rd_data;

    modport slave (
        input  req, req_we, req_addr, req_wr_data, ram_rd_data,
        output ack, rd_valid, rd_data, ram_addr, ram_we, ram_wr_data
    );

    modport master (
        output req, req_we, req_addr, req_wr_data, ram_rd_data,
        input  ack, rd_valid, rd_data, ram_addr, ram_we, ram_wr_data
    );
endinterface

// File: rtl/rr_arb.sv
// Round-robin picker: combinational grant from a registered priority pointer.
module rr_arb
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic            update,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    always_comb begin
        logic [MAX_NREQ-1:0] onehot;
        logic                found;
        int                  cand;
        grant  = '0;
        found  = 1'b0;
        onehot = '0;
        cand   = 0;
        // Search upward from the pointer, wrapping at NREQ.
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
        onehot[NREQ-1:0] = grant;
        grant_idx = IDXW'(onehot_to_idx(onehot));
        ptr_d = ptr_q;
        if (update && found) begin
            ptr_d = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_sp_arb.sv
// Initialises a single-port async-read RAM, then shares it round-robin
// between NREQ requesters, one access per cycle.
module ram_sp_arb
    import ram_arb_pkg::*;
#(
    parameter int                   DATAWIDTH  = 8,
    parameter int                   ADDRWIDTH  = 9,
    parameter int                   NREQ       = 2,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         clear,
    output logic         init_done,
    ram_sp_arb_if.slave  bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic                 init_done_q, init_done_d;
    logic [NREQ-1:0]      rd_valid_q, rd_valid_d;
    logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDRWIDTH-1:0] last_addr_q, last_addr_d;

    logic [NREQ-1:0]      grant;
    logic [IDXW-1:0]      grant_idx;
    logic                 run;
    logic [ADDRWIDTH-1:0] ram_addr;
    logic                 ram_we;
    logic [DATAWIDTH-1:0] ram_wr_data;

    logic [ADDRWIDTH-1:0] addr_arr [NREQ];
    logic [DATAWIDTH-1:0] wd_arr   [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*ADDRWIDTH +: ADDRWIDTH];
            assign wd_arr[gi]   = bus.req_wr_data[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    assign run = (state_q == ST_RUN);

    rr_arb #(.NREQ(NREQ), .IDXW(IDXW)) u_rr_arb (
        .clk       (clk),
        .rst_n     (reset_l),
        .req       (bus.req),
        .enable    (run),
        .update    (run),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rd_valid_d  = '0;
        rd_data_d   = rd_data_q;
        ram_addr    = last_addr_q;
        ram_we      = 1'b0;
        ram_wr_data = '0;
        case (state_q)
            ST_INIT: begin
                ram_addr    = cnt_q;
                ram_we      = 1'b1;
                ram_wr_data = INIT_VALUE;
                if (clear) begin
                    cnt_d = '0;
                end else if (cnt_q == {ADDRWIDTH{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + ADDRWIDTH'(1);
                end
            end
            ST_RUN: begin
                if (|grant) begin
                    ram_addr    = addr_arr[grant_idx];
                    ram_we      = bus.req_we[grant_idx];
                    ram_wr_data = wd_arr[grant_idx];
                    // Async RAM data is captured on the same edge that retires the access.
                    if (!bus.req_we[grant_idx]) begin
                        rd_valid_d = grant;
                        rd_data_d  = bus.ram_rd_data;
                    end
                end
                if (clear) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    init_done_d = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
        last_addr_d = ram_addr;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign init_done       = init_done_q;
    assign bus.ack         = grant;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_we      = ram_we;
    assign bus.ram_wr_data = ram_wr_data;

endmodule
